// File: rtl/hazard_stall_unit_if.sv
// ============================================================================
// Module : hazard_stall_unit_if
// Brief  : Hazard inputs and pipeline-control outputs of hazard_stall_unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_stall_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] i_if_id_rs;
  logic [REG_ADDR_W-1:0] i_if_id_rt;
  logic                  i_if_id_uses_rs;
  logic                  i_if_id_uses_rt;
  logic [REG_ADDR_W-1:0] i_id_ex_rd;
  logic                  i_id_ex_mem_read;
  logic                  i_id_ex_reg_write;
  logic                  i_div_start;
  logic                  i_branch_taken;
  logic                  o_pc_write;
  logic                  o_if_id_write;
  logic                  o_if_id_flush;
  logic                  o_id_ex_write;
  logic                  o_id_ex_bubble;
  logic                  o_ex_mem_bubble;
  logic                  o_div_done;
  logic [CNT_W-1:0]      o_stall_cycles;

  modport master (
    output i_if_id_rs, i_if_id_rt, i_if_id_uses_rs, i_if_id_uses_rt,
           i_id_ex_rd, i_id_ex_mem_read, i_id_ex_reg_write,
           i_div_start, i_branch_taken,
    input  o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_write,
           o_id_ex_bubble, o_ex_mem_bubble, o_div_done, o_stall_cycles
  );

  modport slave (
    input  i_if_id_rs, i_if_id_rt, i_if_id_uses_rs, i_if_id_uses_rt,
           i_id_ex_rd, i_id_ex_mem_read, i_id_ex_reg_write,
           i_div_start, i_branch_taken,
    output o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_write,
           o_id_ex_bubble, o_ex_mem_bubble, o_div_done, o_stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_unit.sv
// ============================================================================
// Module : hazard_stall_unit
// Brief  : Load-use / multi-cycle divide stall and taken-branch flush control.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int DIV_LATENCY = 8,
  parameter int CNT_W       = 32
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  hazard_stall_unit_if.slave   hz
);

  localparam int               c_DCNT_W   = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [c_DCNT_W-1:0] c_DIV_INIT = c_DCNT_W'(DIV_LATENCY - 2);
  localparam logic [0:0]       S_IDLE     = 1'b0;
  localparam logic [0:0]       S_DIV_BUSY = 1'b1;

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic [c_DCNT_W-1:0] r_div_cnt;
  logic [c_DCNT_W-1:0] w_div_cnt_nxt;
  logic [CNT_W-1:0]    r_stall_cycles;

  logic w_load_use;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_write;
  logic w_id_ex_bubble;
  logic w_ex_mem_bubble;
  logic w_div_done;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign w_load_use = hz.i_id_ex_mem_read && hz.i_id_ex_reg_write && (hz.i_id_ex_rd != '0)
                      && ((hz.i_if_id_uses_rs && (hz.i_if_id_rs == hz.i_id_ex_rd))
                       || (hz.i_if_id_uses_rt && (hz.i_if_id_rt == hz.i_id_ex_rd)));

  always_comb begin
    w_pc_write      = 1'b1;
    w_if_id_write   = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_write   = 1'b1;
    w_id_ex_bubble  = 1'b0;
    w_ex_mem_bubble = 1'b0;
    w_div_done      = 1'b0;
    w_state_nxt     = r_state;
    w_div_cnt_nxt   = r_div_cnt;
    case (r_state)
      S_IDLE: begin
        if (hz.i_branch_taken) begin
          w_if_id_flush  = 1'b1;
          w_id_ex_bubble = 1'b1;
        end else if (hz.i_div_start) begin
          w_pc_write      = 1'b0;
          w_if_id_write   = 1'b0;
          w_id_ex_write   = 1'b0;
          w_ex_mem_bubble = 1'b1;
          w_state_nxt     = S_DIV_BUSY;
          w_div_cnt_nxt   = c_DIV_INIT;
        end else if (w_load_use) begin
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b0;
          w_id_ex_bubble = 1'b1;
        end
      end
      S_DIV_BUSY: begin
        if (r_div_cnt != '0) begin
          w_pc_write      = 1'b0;
          w_if_id_write   = 1'b0;
          w_id_ex_write   = 1'b0;
          w_ex_mem_bubble = 1'b1;
          w_div_cnt_nxt   = r_div_cnt - 1'b1;
        end else begin
          // Final divide cycle: EX advances, yet the ID instruction may still be a load consumer.
          w_div_done  = 1'b1;
          w_state_nxt = S_IDLE;
          if (w_load_use) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_div_cnt      <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      if (!w_pc_write && (r_stall_cycles != {CNT_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign hz.o_pc_write      = w_pc_write;
  assign hz.o_if_id_write   = w_if_id_write;
  assign hz.o_if_id_flush   = w_if_id_flush;
  assign hz.o_id_ex_write   = w_id_ex_write;
  assign hz.o_id_ex_bubble  = w_id_ex_bubble;
  assign hz.o_ex_mem_bubble = w_ex_mem_bubble;
  assign hz.o_div_done      = w_div_done;
  assign hz.o_stall_cycles  = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// ============================================================================
// Module : tb_hazard_stall_unit
// Brief  : Checks two hazard_stall_unit instances (latency 8 / 32-bit count and
//          latency 2 / 2-bit count) against a cycle-count reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_unit;

  logic clk;
  logic rst_n;

  logic [4:0] t_rs, t_rt, t_rd;
  logic       t_uses_rs, t_uses_rt, t_mem_read, t_reg_write, t_div_start, t_branch;

  hazard_stall_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) hz0 ();
  hazard_stall_unit_if #(.REG_ADDR_W(5), .CNT_W(2))  hz1 ();

  assign hz0.i_if_id_rs = t_rs;        assign hz1.i_if_id_rs = t_rs;
  assign hz0.i_if_id_rt = t_rt;        assign hz1.i_if_id_rt = t_rt;
  assign hz0.i_if_id_uses_rs = t_uses_rs;   assign hz1.i_if_id_uses_rs = t_uses_rs;
  assign hz0.i_if_id_uses_rt = t_uses_rt;   assign hz1.i_if_id_uses_rt = t_uses_rt;
  assign hz0.i_id_ex_rd = t_rd;        assign hz1.i_id_ex_rd = t_rd;
  assign hz0.i_id_ex_mem_read = t_mem_read; assign hz1.i_id_ex_mem_read = t_mem_read;
  assign hz0.i_id_ex_reg_write = t_reg_write; assign hz1.i_id_ex_reg_write = t_reg_write;
  assign hz0.i_div_start = t_div_start; assign hz1.i_div_start = t_div_start;
  assign hz0.i_branch_taken = t_branch;  assign hz1.i_branch_taken = t_branch;

  hazard_stall_unit #(.REG_ADDR_W(5), .DIV_LATENCY(8), .CNT_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .hz(hz0.slave));
  hazard_stall_unit #(.REG_ADDR_W(5), .DIV_LATENCY(2), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .hz(hz1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, div_done}
  logic [6:0] ctrl [2];
  assign ctrl[0] = {hz0.o_pc_write, hz0.o_if_id_write, hz0.o_if_id_flush, hz0.o_id_ex_write,
                    hz0.o_id_ex_bubble, hz0.o_ex_mem_bubble, hz0.o_div_done};
  assign ctrl[1] = {hz1.o_pc_write, hz1.o_if_id_write, hz1.o_if_id_flush, hz1.o_id_ex_write,
                    hz1.o_id_ex_bubble, hz1.o_ex_mem_bubble, hz1.o_div_done};
  logic [31:0] cnt [2];
  assign cnt[0] = hz0.o_stall_cycles;
  assign cnt[1] = {30'b0, hz1.o_stall_cycles};

  localparam logic [6:0] RUN   = 7'b1101000;
  localparam logic [6:0] LU    = 7'b0001100;
  localparam logic [6:0] DSTL  = 7'b0000010;
  localparam logic [6:0] FLUSH = 7'b1111100;

  int          checks = 0;
  int          failures = 0;
  int          m_lat  [2] = '{8, 2};
  longint      m_max  [2] = '{64'hFFFF_FFFF, 64'd3};
  bit          m_busy [2];
  int          m_left [2];
  longint      m_cnt  [2];
  logic [6:0]  exp_ctrl [2];

  // The divide occupies EX for m_lat cycles: m_lat-1 stall cycles then one done cycle.
  task automatic model_eval();
    bit lu;
    lu = t_mem_read && t_reg_write && (t_rd != 0) &&
         ((t_uses_rs && t_rs == t_rd) || (t_uses_rt && t_rt == t_rd));
    for (int k = 0; k < 2; k++) begin
      if (m_busy[k]) exp_ctrl[k] = (m_left[k] > 0) ? DSTL : (lu ? (LU | 7'b1) : (RUN | 7'b1));
      else if (t_branch)    exp_ctrl[k] = FLUSH;
      else if (t_div_start) exp_ctrl[k] = DSTL;
      else if (lu)          exp_ctrl[k] = LU;
      else                  exp_ctrl[k] = RUN;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_left[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!exp_ctrl[k][6] && m_cnt[k] < m_max[k]) m_cnt[k]++;
      if (m_busy[k]) begin
        if (m_left[k] > 0) m_left[k]--;
        else m_busy[k] = 0;
      end else if (!t_branch && t_div_start) begin
        m_busy[k] = 1;
        m_left[k] = m_lat[k] - 2;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    t_rs = 0; t_rt = 0; t_rd = 0; t_uses_rs = 0; t_uses_rt = 0;
    t_mem_read = 0; t_reg_write = 0; t_div_start = 0; t_branch = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ctrl[k] !== RUN) begin
        failures++; $display("FAIL reset_ctrl%0d got %b want %b", k, ctrl[k], RUN);
      end
      checks++;
      if (cnt[k] !== 32'd0) begin
        failures++; $display("FAIL reset_cnt%0d got %0d want 0", k, cnt[k]);
      end
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_load_use();
    longint base;
    base = m_cnt[0];
    t_mem_read = 1; t_reg_write = 1; t_rd = 5; t_rs = 5; t_uses_rs = 1;
    #1; model_eval();
    checks++;
    if (ctrl[0] !== LU || exp_ctrl[0] !== LU) begin
      failures++; $display("FAIL load_use_stall got %b want %b", ctrl[0], LU);
    end
    tick();
    t_rd = 0; t_mem_read = 0;
    #1; model_eval();
    checks++;
    if (ctrl[0] !== RUN) begin
      failures++; $display("FAIL load_use_release got %b want %b", ctrl[0], RUN);
    end
    checks++;
    if (cnt[0] !== 32'(base + 1)) begin
      failures++; $display("FAIL load_use_cnt got %0d want %0d", cnt[0], base + 1);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_no_hazard();
    t_mem_read = 1; t_reg_write = 1; t_rd = 0; t_rs = 0; t_uses_rs = 1;
    #1; model_eval();
    checks++;
    if (ctrl[0] !== RUN) begin
      failures++; $display("FAIL r0_no_stall got %b want %b", ctrl[0], RUN);
    end
    tick();
    t_rd = 7; t_rt = 7; t_uses_rt = 0; t_rs = 3;
    #1; model_eval();
    checks++;
    if (ctrl[0] !== RUN) begin
      failures++; $display("FAIL unused_rt_no_stall got %b want %b", ctrl[0], RUN);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_divide();
    longint base;
    int stalls, done_at;
    base = m_cnt[0]; stalls = 0; done_at = -1;
    for (int c = 0; c < 10; c++) begin
      t_div_start = (c == 0);
      #1; model_eval();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (ctrl[k] !== exp_ctrl[k]) begin
          failures++; $display("FAIL divide%0d_c%0d got %b want %b", k, c, ctrl[k], exp_ctrl[k]);
        end
      end
      if (!ctrl[0][6]) stalls++;
      if (ctrl[0][0] && done_at < 0) done_at = c;
      tick();
    end
    checks++;
    if (stalls != 7 || done_at != 7) begin
      failures++; $display("FAIL divide_len stalls %0d done_at %0d want 7 7", stalls, done_at);
    end
    checks++;
    if (cnt[0] !== 32'(base + 7)) begin
      failures++; $display("FAIL divide_cnt got %0d want %0d", cnt[0], base + 7);
    end
    idle_inputs();
  endtask

  task automatic test_branch_priority();
    t_mem_read = 1; t_reg_write = 1; t_rd = 9; t_rt = 9; t_uses_rt = 1; t_branch = 1;
    #1; model_eval();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ctrl[k] !== FLUSH) begin
        failures++; $display("FAIL branch_prio%0d got %b want %b", k, ctrl[k], FLUSH);
      end
    end
    tick();
    t_div_start = 1;
    #1; model_eval();
    checks++;
    if (ctrl[0] !== FLUSH) begin
      failures++; $display("FAIL branch_over_div got %b want %b", ctrl[0], FLUSH);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_divide();
    t_div_start = 1;
    #1; model_eval(); tick();
    t_div_start = 0;
    #1; model_eval(); tick();
    rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (ctrl[0] !== RUN || cnt[0] !== 32'd0) begin
      failures++; $display("FAIL reset_mid_div got %b/%0d want %b/0", ctrl[0], cnt[0], RUN);
    end
    #2; rst_n = 1;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      #1; model_eval();
      checks++;
      if (ctrl[0] !== RUN) begin
        failures++; $display("FAIL post_reset_c%0d got %b want %b", c, ctrl[0], RUN);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 12; c++) begin
      t_div_start = 1;
      #1; model_eval();
      checks++;
      if (ctrl[1] !== exp_ctrl[1] || cnt[1] !== 32'(m_cnt[1])) begin
        failures++; $display("FAIL sat_c%0d got %b/%0d want %b/%0d",
                             c, ctrl[1], cnt[1], exp_ctrl[1], m_cnt[1]);
      end
      tick();
    end
    checks++;
    if (cnt[1] !== 32'd3) begin
      failures++; $display("FAIL sat_hold got %0d want 3", cnt[1]);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      t_rs = 5'($urandom_range(0, 3)); t_rt = 5'($urandom_range(0, 3));
      t_rd = 5'($urandom_range(0, 3));
      t_uses_rs = 1'($urandom); t_uses_rt = 1'($urandom);
      t_mem_read = 1'($urandom); t_reg_write = ($urandom_range(0, 3) != 0);
      t_div_start = ($urandom_range(0, 9) == 0);
      t_branch = ($urandom_range(0, 6) == 0);
      #1; model_eval();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (ctrl[k] !== exp_ctrl[k] || cnt[k] !== 32'(m_cnt[k])) begin
          failures++; $display("FAIL random%0d_c%0d got %b/%0d want %b/%0d",
                               k, c, ctrl[k], cnt[k], exp_ctrl[k], m_cnt[k]);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_no_hazard();
    test_divide();
    test_branch_priority();
    test_reset_mid_divide();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
